mine_field_gen: RTL and testbench

- Generates the 8x8 minesweeper mine map: a 64-bit mask with exactly NUM_MINES bits set, placed pseudo-randomly.
- The cell under the player's first click is always left clear.
- Sits directly upstream of the board population counter, which consumes mine_map to produce mine totals.
- Placement uses a free-running 16-bit LFSR and a rejection-sampling state machine, one candidate per clock.

---
 rtl/mine_field_gen.sv | 119 +++++++++++
 tb/tb_mine_field_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_field_gen.sv
// mine_field_gen: places NUM_MINES mines pseudo-randomly on an 8x8 board,
// keeping the first-click cell clear. One LFSR candidate is tested per clock
// while busy; done pulses for one cycle when the last mine lands.
module mine_field_gen #(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  safe_cell,
  output logic        busy,
  output logic        done,
  output logic [63:0] mine_map,
  output logic [5:0]  mines_placed
);

  // Reject illegal configurations at elaboration time.
  if (NUM_MINES < 1 || NUM_MINES > 63) begin : g_bad_num_mines
    $error("mine_field_gen: NUM_MINES must be in 1..63");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("mine_field_gen: LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLACE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Count value at which the next accepted mine is the final one.
  localparam logic [5:0] LAST_COUNT = 6'(NUM_MINES - 1);

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [63:0] map_q;
  logic [5:0]  count_q;
  logic [5:0]  safe_q;
  logic        busy_q;
  logic        done_q;

  logic [5:0]  cand;
  logic        cand_ok;
  logic        last_mine;

  // Galois right-shift step; the toggle mask keeps the register off zero.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Candidate is accepted only if it is not the safe cell and not already mined.
  always_comb begin
    cand      = lfsr_q[5:0];
    cand_ok   = (cand != safe_q) && !map_q[cand];
    last_mine = (count_q == LAST_COUNT);
  end

  // Free-running LFSR: advances every cycle regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Placement FSM with its map, count, latched safe cell and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      map_q   <= 64'd0;
      count_q <= 6'd0;
      safe_q  <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            map_q   <= 64'd0;
            count_q <= 6'd0;
            safe_q  <= safe_cell;
            busy_q  <= 1'b1;
            state_q <= S_PLACE;
          end
        end
        S_PLACE: begin
          if (cand_ok) begin
            map_q[cand] <= 1'b1;
            count_q     <= count_q + 6'd1;
            if (last_mine) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mine_map     = map_q;
  assign mines_placed = count_q;

endmodule

// File: tb/tb_mine_field_gen.sv
// Scoreboard bench for mine_field_gen: a golden LFSR replay predicts each map
// and its completion cycle when start is driven; monitors pop and compare on done.
module tb_mine_field_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 10 mines. Instance B: 63 mines (full board but one).
  logic        rst_a, start_a, busy_a, done_a;
  logic [5:0]  safe_a, placed_a;
  logic [63:0] map_a;
  logic        rst_b, start_b, busy_b, done_b;
  logic [5:0]  safe_b, placed_b;
  logic [63:0] map_b;

  mine_field_gen #(.NUM_MINES(10), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst_a), .start(start_a), .safe_cell(safe_a),
    .busy(busy_a), .done(done_a), .mine_map(map_a), .mines_placed(placed_a)
  );

  mine_field_gen #(.NUM_MINES(63), .LFSR_SEED(SEED)) dut63 (
    .clk(clk), .rst(rst_b), .start(start_b), .safe_cell(safe_b),
    .busy(busy_b), .done(done_b), .mine_map(map_b), .mines_placed(placed_b)
  );

  typedef struct {
    logic [63:0] map;
    int unsigned done_cyc;
    bit          chk_cyc;
    logic [5:0]  safe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int done_cnt_a = 0;
  logic [15:0] m_lfsr_a;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR for instance A, tracking its reset exactly.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) m_lfsr_a <= SEED;
    else       m_lfsr_a <= lfsr_nx(m_lfsr_a);
  end

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Replay placement from the LFSR value seen at the accepting edge.
  function automatic exp_t build_exp(input logic [15:0] l_at_start, input logic [5:0] s,
                                     input int n, input int unsigned cyc_now);
    exp_t e;
    logic [15:0] l;
    logic [5:0]  c;
    int cnt;
    int k;
    e.map = 64'd0;
    l = lfsr_nx(l_at_start);
    cnt = 0;
    k = 0;
    while (cnt < n && k < 100000) begin
      k++;
      c = l[5:0];
      if (c != s && !e.map[c]) begin
        e.map[c] = 1'b1;
        cnt++;
      end
      l = lfsr_nx(l);
    end
    e.done_cyc = cyc_now + 1 + k;
    e.chk_cyc  = 1'b1;
    e.safe     = s;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_field(input string tag, input logic [63:0] map, input logic [5:0] mp,
                             input int unsigned c, input int n, input exp_t e);
    chk({tag, "_map"}, map, e.map);
    chk({tag, "_popcount"}, 64'($countones(map)), 64'(n));
    chk({tag, "_placed"}, 64'(mp), 64'(n));
    chk({tag, "_safe_clear"}, 64'(map[e.safe]), 64'd0);
    if (e.chk_cyc) chk({tag, "_done_cycle"}, 64'(c), 64'(e.done_cyc));
  endtask

  // Monitor A: invariants every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      chk("a_popcount_inv", 64'(placed_a), 64'($countones(map_a)));
      chk("a_not_over_max", 64'(placed_a <= 6'd10), 64'd1);
      chk("a_busy_done_excl", 64'(busy_a & done_a), 64'd0);
      if (done_a) begin
        done_cnt_a++;
        if (q_a.size() == 0) chk("a_unexpected_done", 64'd1, 64'd0);
        else begin
          e = q_a.pop_front();
          check_field("a", map_a, placed_a, cyc, 10, e);
        end
      end
    end
  end

  // Monitor B: same scoreboard flow for the 63-mine instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      chk("b_popcount_inv", 64'(placed_b), 64'($countones(map_b)));
      if (done_b) begin
        if (q_b.size() == 0) chk("b_unexpected_done", 64'd1, 64'd0);
        else begin
          e = q_b.pop_front();
          check_field("b", map_b, placed_b, cyc, 63, e);
        end
      end
    end
  end

  // Run one field on A; hold=1 wiggles start through PLACE and holds it over DONE.
  task automatic run_field_a(input logic [5:0] s, input bit hold);
    bit got;
    int d0;
    logic [5:0] prev;
    safe_a  = s;
    start_a = 1'b1;
    q_a.push_back(build_exp(m_lfsr_a, s, 10, cyc));
    d0 = done_cnt_a;
    @(negedge clk);
    chk("a_accept_map_clear", map_a, 64'd0);
    chk("a_accept_placed_zero", 64'(placed_a), 64'd0);
    chk("a_accept_busy", 64'(busy_a), 64'd1);
    if (!hold) start_a = 1'b0;
    prev = placed_a;
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done_a) begin
        got = 1'b1;
        break;
      end
      if (hold) start_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (hold) chk("a_placed_monotonic", 64'(placed_a >= prev), 64'd1);
      prev = placed_a;
    end
    if (!got) begin
      chk("a_done_timeout", 64'd0, 64'd1);
      start_a = 1'b0;
    end else begin
      if (hold) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      if (hold) begin
        chk("a_no_restart_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        chk("a_no_restart_busy2", 64'(busy_a), 64'd0);
        chk("a_single_done", 64'(done_cnt_a - d0), 64'd1);
      end
    end
  endtask

  task automatic run_field_b(input logic [5:0] s, input logic [63:0] exp_map);
    exp_t e;
    bit got;
    e.map = exp_map;
    e.done_cyc = 0;
    e.chk_cyc = 1'b0;
    e.safe = s;
    safe_b  = s;
    start_b = 1'b1;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if (done_b) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("b_done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] first_map;
    bit hit4;
    rst_a = 1'b1; start_a = 1'b0; safe_a = 6'd0;
    rst_b = 1'b1; start_b = 1'b0; safe_b = 6'd0;
    repeat (3) @(negedge clk);
    chk("reset_map", map_a, 64'd0);
    chk("reset_placed", 64'(placed_a), 64'd0);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_done", 64'(done_a), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);

    // First field, then a back-to-back second field.
    run_field_a(6'd27, 1'b0);
    first_map = map_a;
    run_field_a(6'd27, 1'b0);
    chk("a_b2b_maps_differ", 64'(map_a != first_map), 64'd1);

    // start held/toggled through PLACE and DONE.
    run_field_a(6'd40, 1'b1);

    // Reset asserted mid-cycle while four mines are placed.
    safe_a = 6'd27;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    hit4 = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (placed_a == 6'd4) begin
        hit4 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("a_reached_four", 64'(hit4), 64'd1);
    #2 rst_a = 1'b1;
    #1;
    chk("a_midrst_map", map_a, 64'd0);
    chk("a_midrst_placed", 64'(placed_a), 64'd0);
    chk("a_midrst_busy", 64'(busy_a), 64'd0);
    chk("a_midrst_done", 64'(done_a), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    run_field_a(6'd27, 1'b0);

    // Boundary safe cells with a 63-mine board.
    run_field_b(6'd0,  64'hFFFF_FFFF_FFFF_FFFE);
    run_field_b(6'd63, 64'h7FFF_FFFF_FFFF_FFFF);

    repeat (2) @(negedge clk);
    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
